// File: rtl/fluxo_dados_jogo.sv
// Game datapath: counters E/L/M/T, button register R, 16x4 sequence ROM and a button-press edge detector.
// Every counter and register updates on the next clock edge; all status outputs are combinational; no backpressure.
module fluxo_dados_jogo #(
  parameter int M_MODULO = 2000,
  parameter int T_MODULO = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes,
  input  logic       zeraE,
  input  logic       contaE,
  input  logic       zeraL,
  input  logic       contaL,
  input  logic       zeraM,
  input  logic       contaM,
  input  logic       zeraR,
  input  logic       registraR,
  input  logic       contaT,
  input  logic [1:0] seletor,
  output logic       jogada,
  output logic       timeout,
  output logic       botoesIgualMemoria,
  output logic       fimE,
  output logic       fimL,
  output logic       meioL,
  output logic       enderecoIgualLimite,
  output logic       enderecoMenorLimite,
  output logic       fimM,
  output logic       meioM,
  output logic [3:0] leds,
  output logic [3:0] db_contagem,
  output logic [3:0] db_limite,
  output logic [3:0] db_memoria,
  output logic [3:0] db_jogada
);

  localparam int MW = (M_MODULO > 1) ? $clog2(M_MODULO) : 1;
  localparam int TW = (T_MODULO > 1) ? $clog2(T_MODULO) : 1;

  logic [3:0]    contE;
  logic [3:0]    contL;
  logic [MW-1:0] contM;
  logic [TW-1:0] contT;
  logic [3:0]    regR;
  logic          botaoAnterior;
  logic [3:0]    memoria;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contE <= '0;
      contL <= '0;
    end else begin
      if (zeraE)       contE <= '0;
      else if (contaE) contE <= contE + 4'd1;
      if (zeraL)       contL <= '0;
      else if (contaL) contL <= contL + 4'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contM <= '0;
    end else if (zeraM) begin
      contM <= '0;
    end else if (contaM) begin
      contM <= (contM == MW'(M_MODULO - 1)) ? '0 : contM + MW'(1);
    end
  end

  // A fresh press restarts the move timer; it holds at the last value until cleared.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contT <= '0;
    end else if (!contaT || jogada) begin
      contT <= '0;
    end else if (contT != TW'(T_MODULO - 1)) begin
      contT <= contT + TW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      regR          <= '0;
      botaoAnterior <= 1'b0;
    end else begin
      if (zeraR)          regR <= '0;
      else if (registraR) regR <= botoes;
      botaoAnterior <= |botoes;
    end
  end

  always_comb begin
    memoria = 4'b0001;
    case (contE)
      4'd0:  memoria = 4'b0001;
      4'd1:  memoria = 4'b0010;
      4'd2:  memoria = 4'b0100;
      4'd3:  memoria = 4'b1000;
      4'd4:  memoria = 4'b0100;
      4'd5:  memoria = 4'b0010;
      4'd6:  memoria = 4'b0001;
      4'd7:  memoria = 4'b0001;
      4'd8:  memoria = 4'b0010;
      4'd9:  memoria = 4'b0010;
      4'd10: memoria = 4'b0100;
      4'd11: memoria = 4'b0100;
      4'd12: memoria = 4'b1000;
      4'd13: memoria = 4'b1000;
      4'd14: memoria = 4'b0001;
      4'd15: memoria = 4'b0100;
      default: memoria = 4'b0001;
    endcase
  end

  always_comb begin
    leds = 4'b0000;
    case (seletor)
      2'b01:   leds = memoria;
      2'b10:   leds = botoes;
      default: leds = 4'b0000;
    endcase
  end

  assign jogada              = (|botoes) & ~botaoAnterior;
  assign timeout             = (contT == TW'(T_MODULO - 1)) & contaT;
  assign botoesIgualMemoria  = (regR == memoria);
  assign fimE                = (contE == 4'd15);
  assign fimL                = (contL == 4'd15);
  assign meioL               = (contL == 4'd7);
  assign enderecoIgualLimite = (contE == contL);
  assign enderecoMenorLimite = (contE < contL);
  assign fimM                = (contM == MW'(M_MODULO - 1));
  assign meioM               = (contM == MW'(M_MODULO / 2));
  assign db_contagem         = contE;
  assign db_limite           = contL;
  assign db_memoria          = memoria;
  assign db_jogada           = regR;

endmodule

// File: tb/tb_fluxo_dados_jogo.sv
// Directed bench for fluxo_dados_jogo with M_MODULO=10 and T_MODULO=8.
module tb_fluxo_dados_jogo;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] botoes;
  logic       zeraE, contaE, zeraL, contaL, zeraM, contaM, zeraR, registraR, contaT;
  logic [1:0] seletor;
  logic       jogada, timeout, botoesIgualMemoria, fimE, fimL, meioL;
  logic       enderecoIgualLimite, enderecoMenorLimite, fimM, meioM;
  logic [3:0] leds, db_contagem, db_limite, db_memoria, db_jogada;

  int tests  = 0;
  int failed = 0;

  fluxo_dados_jogo #(.M_MODULO(10), .T_MODULO(8)) dut (
    .clock(clock), .reset(reset), .botoes(botoes),
    .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL),
    .zeraM(zeraM), .contaM(contaM), .zeraR(zeraR), .registraR(registraR),
    .contaT(contaT), .seletor(seletor),
    .jogada(jogada), .timeout(timeout), .botoesIgualMemoria(botoesIgualMemoria),
    .fimE(fimE), .fimL(fimL), .meioL(meioL),
    .enderecoIgualLimite(enderecoIgualLimite), .enderecoMenorLimite(enderecoMenorLimite),
    .fimM(fimM), .meioM(meioM), .leds(leds),
    .db_contagem(db_contagem), .db_limite(db_limite),
    .db_memoria(db_memoria), .db_jogada(db_jogada)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic chkIdle(input string pfx);
    chk({pfx, " jogada"}, 32'(jogada), 0);
    chk({pfx, " timeout"}, 32'(timeout), 0);
    chk({pfx, " fimE"}, 32'(fimE), 0);
    chk({pfx, " fimL"}, 32'(fimL), 0);
    chk({pfx, " meioL"}, 32'(meioL), 0);
    chk({pfx, " igualLim"}, 32'(enderecoIgualLimite), 1);
    chk({pfx, " menorLim"}, 32'(enderecoMenorLimite), 0);
    chk({pfx, " fimM"}, 32'(fimM), 0);
    chk({pfx, " meioM"}, 32'(meioM), 0);
    chk({pfx, " igualMem"}, 32'(botoesIgualMemoria), 0);
    chk({pfx, " leds"}, 32'(leds), 0);
    chk({pfx, " db_memoria"}, 32'(db_memoria), 1);
    chk({pfx, " db_contagem"}, 32'(db_contagem), 0);
    chk({pfx, " db_limite"}, 32'(db_limite), 0);
    chk({pfx, " db_jogada"}, 32'(db_jogada), 0);
  endtask

  initial begin
    reset = 1'b1; botoes = 4'b0000; seletor = 2'b00;
    zeraE = 0; contaE = 0; zeraL = 0; contaL = 0; zeraM = 0; contaM = 0;
    zeraR = 0; registraR = 0; contaT = 0;
    #3;
    chkIdle("rst");
    #9 reset = 1'b0;

    // E counts through 15 and wraps
    contaE = 1;
    for (int i = 1; i <= 15; i++) begin
      step();
      chk("E count", 32'(db_contagem), 32'(i));
    end
    chk("fimE at 15", 32'(fimE), 1);
    step();
    chk("E wrap", 32'(db_contagem), 0);
    chk("fimE after wrap", 32'(fimE), 0);
    step();
    zeraE = 1;
    step();
    zeraE = 0; contaE = 0;
    chk("zeraE priority", 32'(db_contagem), 0);

    // L=3 against E=0..3, then L=7
    contaL = 1;
    step(); step(); step();
    contaL = 0;
    chk("L=3", 32'(db_limite), 3);
    for (int e = 0; e <= 3; e++) begin
      chk("menorLim", 32'(enderecoMenorLimite), 32'(e < 3));
      chk("igualLim", 32'(enderecoIgualLimite), 32'(e == 3));
      contaE = 1; step(); contaE = 0;
    end
    chk("meioL at 3", 32'(meioL), 0);
    contaL = 1;
    step(); step(); step(); step();
    contaL = 0;
    chk("meioL at 7", 32'(meioL), 1);

    // E=2, press 0100 held 5 cycles
    zeraE = 1; step(); zeraE = 0;
    contaE = 1; step(); step(); contaE = 0;
    chk("E=2", 32'(db_contagem), 2);
    botoes = 4'b0100; registraR = 1;
    #1;
    chk("jogada pulse", 32'(jogada), 1);
    step();
    registraR = 0;
    chk("jogada drop", 32'(jogada), 0);
    chk("R=0100", 32'(db_jogada), 4);
    chk("igualMem E=2", 32'(botoesIgualMemoria), 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("jogada held", 32'(jogada), 0);
    end
    seletor = 2'b10; #1;
    chk("leds=botoes", 32'(leds), 4'b0100);
    botoes = 4'b0000; seletor = 2'b00;
    step();
    botoes = 4'b1000; registraR = 1;
    step();
    registraR = 0; botoes = 4'b0000;
    chk("R=1000", 32'(db_jogada), 8);
    chk("igualMem mismatch", 32'(botoesIgualMemoria), 0);
    contaE = 1; step(); contaE = 0;
    seletor = 2'b01; #1;
    chk("leds ROM[3]", 32'(leds), 4'b1000);
    seletor = 2'b11; #1;
    chk("leds sel11", 32'(leds), 0);
    seletor = 2'b00;

    // Move timer
    contaT = 1;
    for (int i = 0; i < 6; i++) step();
    chk("timeout early", 32'(timeout), 0);
    step();
    chk("timeout T=7", 32'(timeout), 1);
    step();
    chk("timeout saturate", 32'(timeout), 1);
    botoes = 4'b0001; #1;
    chk("press at timeout jogada", 32'(jogada), 1);
    step();
    chk("timer restart", 32'(timeout), 0);
    botoes = 4'b0000;
    contaT = 0; #1;
    chk("timeout contaT=0", 32'(timeout), 0);

    // M counter
    contaM = 1;
    for (int i = 0; i < 5; i++) step();
    chk("meioM M=5", 32'(meioM), 1);
    chk("fimM M=5", 32'(fimM), 0);
    for (int i = 0; i < 4; i++) step();
    chk("fimM M=9", 32'(fimM), 1);
    step();
    chk("M wrap fimM", 32'(fimM), 0);
    chk("M wrap meioM", 32'(meioM), 0);
    contaM = 0;

    // E=5, L=9, R=0010 then reset mid-cycle
    contaE = 1; contaL = 1;
    step(); step();
    contaE = 0; contaL = 0;
    botoes = 4'b0010; registraR = 1;
    step();
    registraR = 0; botoes = 4'b0000;
    chk("pre E=5", 32'(db_contagem), 5);
    chk("pre L=9", 32'(db_limite), 9);
    chk("pre R=0010", 32'(db_jogada), 2);
    contaE = 1; contaM = 1; contaT = 1;
    #1 reset = 1'b1;
    #1;
    contaT = 0;
    chkIdle("midrst");
    contaT = 1;
    @(negedge clock);
    reset = 1'b0;
    step();
    chk("first count after reset", 32'(db_contagem), 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fluxo_dados_jogo.md
FLUXO_DADOS_JOGO -- requirements
Module: fluxo_dados_jogo

Interface
REQ-001 Parameter M_MODULO, default 2000, cycles per show-timer period (M counter modulus).
REQ-002 Parameter T_MODULO, default 5000, cycles allowed per player move before timeout.
REQ-003 clock  in  1  system clock, all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state.
REQ-005 botoes  in  4  player buttons, one-hot when pressed, 0000 idle.
REQ-006 zeraE, contaE, zeraL, contaL, zeraM, contaM, zeraR, registraR, contaT  in  1 each  control strobes from control unit.
REQ-007 seletor  in  2  LED source select.
REQ-008 jogada, timeout, botoesIgualMemoria, fimE, fimL, meioL, enderecoIgualLimite, enderecoMenorLimite, fimM, meioM  out  1 each  status to control unit.
REQ-009 leds  out  4  LED drive.
REQ-010 db_contagem, db_limite, db_memoria, db_jogada  out  4 each  debug: E count, L count, ROM word at E, register R.

Function
REQ-011 Counter E (4 bit): synchronous zeraE clears; else contaE increments; 15+1 wraps to 0; zeraE has priority over contaE.
REQ-012 Counter L (4 bit): same rules as E with zeraL/contaL.
REQ-013 Counter M (0..M_MODULO-1): zeraM clears (priority); else contaM increments, wrapping M_MODULO-1 -> 0.
REQ-014 Counter T (0..T_MODULO-1): clears whenever contaT=0 or jogada=1; else increments, saturating at T_MODULO-1.
REQ-015 Register R (4 bit): zeraR clears (priority); else registraR loads botoes on that edge.
REQ-016 ROM 16x4, combinational read at address E, contents addr 0..15: 1,2,4,8,4,2,1,1,2,2,4,4,8,8,1,4.
REQ-017 fimE = (E==15); fimL = (L==15); meioL = (L==7).
REQ-018 enderecoIgualLimite = (E==L); enderecoMenorLimite = (E<L), unsigned.
REQ-019 fimM = (M==M_MODULO-1); meioM = (M==M_MODULO/2), integer division.
REQ-020 timeout = (T==T_MODULO-1) and contaT=1; held while both remain true.
REQ-021 botoesIgualMemoria = (R == ROM[E]), combinational.
REQ-022 Edge detector: register P holds previous |botoes each cycle; jogada = (|botoes) & ~P, one-cycle pulse per press, no repeat while held.
REQ-023 Simultaneous press+timeout edge: jogada asserted, T cleared next edge; control unit priority decides outcome.
REQ-024 leds: seletor 00 -> 0000; 01 -> ROM[E]; 10 -> botoes; 11 -> 0000.
REQ-025 db_contagem=E, db_limite=L, db_memoria=ROM[E], db_jogada=R.
REQ-026 All status outputs are combinational from registered state/inputs; no added latency beyond one edge for any counter or register update.

Reset
REQ-027 Asserting reset at any time, including mid-count, immediately sets E=L=M=T=0, R=0000, P=0.
REQ-028 During/after reset with botoes=0000, seletor=00: jogada=0, timeout=0, fimE=fimL=meioL=0, enderecoIgualLimite=1, enderecoMenorLimite=0, fimM=meioM=0, botoesIgualMemoria=0 (ROM[0]=1), leds=0000, db_memoria=0001.
REQ-029 reset released synchronously-safe: first counting occurs on first rising edge after deassertion.

Verification
REQ-030 Reset, contaE for 16 cycles -> fimE=1 at E=15, E=0 after 16th edge; zeraE+contaE same cycle -> E=0.
REQ-031 L=3, step E 0..3 -> enderecoMenorLimite=1 for E=0..2, enderecoIgualLimite=1 only at E=3; L=7 -> meioL=1.
REQ-032 E=2, botoes=0100 held 5 cycles, registraR once -> jogada pulses exactly one cycle, R=0100, botoesIgualMemoria=1; botoes=1000 registered -> 0.
REQ-033 T_MODULO=8, contaT held -> timeout=1 from 8th cycle onward; press during count -> T restarts at 0, timeout=0.
REQ-034 M_MODULO=10, contaM -> meioM at M=5, fimM at M=9, wraps to 0; seletor=01 at E=3 -> leds=1000, seletor=10 -> leds=botoes.
REQ-035 Reset asserted mid-sequence (E=5, L=9, R=0010) -> all state zero within same cycle, outputs per REQ-028.
